// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder that computes {cout,sum} = a + b + cin. One full-adder
//   cell is reused LSB-first, one bit per clock. A carry flop links each bit
//   to the next. A start/busy/done handshake sequences each operation.
//
//   Parameters
//     WIDTH  operand/result width in bits (WIDTH >= 2)
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   operation request, honoured only in IDLE or DONE
//     a, b   in   operands, captured when start is accepted
//     cin    in   carry-in, captured when start is accepted
//     busy   out  high while an operation is in progress
//     done   out  one-cycle pulse when sum/cout carry a fresh result
//     sum    out  result, held until the next completion
//     cout   out  carry-out, held until the next completion
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    fa_sum = x ^ y ^ c;
  endfunction

  // Full-adder carry: majority of the three inputs.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    fa_carry = (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state_r,  state_nxt_s;
  logic [WIDTH-1:0] a_sh_r,   a_sh_nxt_s;
  logic [WIDTH-1:0] b_sh_r,   b_sh_nxt_s;
  logic [WIDTH-1:0] res_r,    res_nxt_s;
  logic             carry_r,  carry_nxt_s;
  logic [CW-1:0]    cnt_r,    cnt_nxt_s;
  logic [WIDTH-1:0] sum_r,    sum_nxt_s;
  logic             cout_r,   cout_nxt_s;
  logic             busy_r;
  logic             done_r;
  logic             bit_sum_s;
  logic             bit_carry_s;
  logic [WIDTH-1:0] res_shift_s;

  // Next-state and datapath update for the serial add sequence.
  always_comb begin
    state_nxt_s = state_r;
    a_sh_nxt_s  = a_sh_r;
    b_sh_nxt_s  = b_sh_r;
    res_nxt_s   = res_r;
    carry_nxt_s = carry_r;
    cnt_nxt_s   = cnt_r;
    sum_nxt_s   = sum_r;
    cout_nxt_s  = cout_r;

    bit_sum_s   = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
    bit_carry_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
    // New bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
    res_shift_s = {bit_sum_s, res_r[WIDTH-1:1]};

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_nxt_s  = a;
          b_sh_nxt_s  = b;
          carry_nxt_s = cin;
          cnt_nxt_s   = '0;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_nxt_s  = {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_nxt_s  = {1'b0, b_sh_r[WIDTH-1:1]};
        carry_nxt_s = bit_carry_s;
        res_nxt_s   = res_shift_s;
        if (cnt_r == LAST_BIT) begin
          // Final bit: publish the result. The counter holds here and does not wrap.
          sum_nxt_s   = res_shift_s;
          cout_nxt_s  = bit_carry_s;
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  // busy and done are decoded from the next state, so they match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_sh_r  <= a_sh_nxt_s;
      b_sh_r  <= b_sh_nxt_s;
      res_r   <= res_nxt_s;
      carry_r <= carry_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sum_r   <= sum_nxt_s;
      cout_r  <= cout_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder with two instances: WIDTH=8 and WIDTH=2.
//   Expected {cout,sum} values are pushed to a queue when an operation starts.
//   They are popped and compared when done rises.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  logic [8:0] sb8[$];
  logic [2:0] sb2[$];

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation. Call at #1 after an edge, in IDLE or DONE.
  // Returns at #1 after the accepting edge, with the inputs scrambled.
  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    sb8.push_back({1'b0, av} + {1'b0, bv} + {8'd0, cv});
    step();
    start8 = 1'b0; a8 = ~av; b8 = bv ^ 8'h5A; cin8 = ~cv;
  endtask

  task automatic wait_done8(input int exp_lat, input string tag);
    int n;
    int nb;
    logic [8:0] e;
    n = 0;
    nb = 0;
    while (done8 !== 1'b1 && n < 40) begin
      if (busy8 === 1'b1) nb++;
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(nb), 32'(exp_lat));
    chk({tag, " busy at done"}, {31'd0, busy8}, 32'd0);
    if (sb8.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s result: observed=%0h expected=<none queued>", tag, {cout8, sum8});
    end else begin
      e = sb8.pop_front();
      chk({tag, " result"}, {23'd0, cout8, sum8}, {23'd0, e});
    end
  endtask

  task automatic go2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    start2 = 1'b1; a2 = av; b2 = bv; cin2 = cv;
    sb2.push_back({1'b0, av} + {1'b0, bv} + {2'd0, cv});
    step();
    start2 = 1'b0; a2 = ~av; b2 = ~bv; cin2 = ~cv;
  endtask

  task automatic wait_done2(input string tag);
    int n;
    logic [2:0] e;
    n = 0;
    while (done2 !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd2);
    if (sb2.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s result: observed=%0h expected=<none queued>", tag, {cout2, sum2});
    end else begin
      e = sb2.pop_front();
      chk({tag, " result"}, {29'd0, cout2, sum2}, {29'd0, e});
    end
  endtask

  initial begin
    logic [4:0] v;

    // Reset held with start asserted.
    rst_n  = 1'b0;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    start2 = 1'b1; a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
    repeat (3) begin
      step();
      chk("reset busy", {31'd0, busy8}, 32'd0);
      chk("reset done", {31'd0, done8}, 32'd0);
      chk("reset sum",  {24'd0, sum8},  32'd0);
      chk("reset cout", {31'd0, cout8}, 32'd0);
    end
    start8 = 1'b0;
    start2 = 1'b0;
    rst_n  = 1'b1;
    step();

    // Basic add, latency and busy length.
    go8(8'h0F, 8'h01, 1'b0);
    wait_done8(8, "basic");
    step();
    chk("basic done pulse width", {31'd0, done8}, 32'd0);
    chk("basic sum held", {24'd0, sum8}, 32'h10);

    // Carry chains.
    go8(8'hFF, 8'h01, 1'b0);
    wait_done8(8, "carry1");
    go8(8'hFF, 8'hFF, 1'b1);
    wait_done8(8, "carry2");
    step();

    // start and new operands during RUN are ignored.
    go8(8'h12, 8'h34, 1'b0);
    step();
    step();
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    step();
    start8 = 1'b0;
    wait_done8(5, "ignore");
    step();
    chk("ignore single done", {31'd0, done8}, 32'd0);
    chk("ignore idle after", {31'd0, busy8}, 32'd0);
    chk("ignore queue empty", 32'(sb8.size()), 32'd0);

    // Back-to-back: second start issued in the DONE cycle.
    go8(8'h0F, 8'h01, 1'b0);
    wait_done8(8, "b2b first");
    go8(8'h80, 8'h80, 1'b0);
    chk("b2b done dropped", {31'd0, done8}, 32'd0);
    chk("b2b busy again", {31'd0, busy8}, 32'd1);
    chk("b2b first held", {24'd0, sum8}, 32'h10);
    wait_done8(8, "b2b second");
    step();

    // Put a nonzero result on the outputs, then reset during a run.
    go8(8'h21, 8'h10, 1'b0);
    wait_done8(8, "pre-reset");
    go8(8'h33, 8'h44, 1'b0);
    step();
    step();
    step();
    chk("midrun busy before reset", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", {31'd0, busy8}, 32'd0);
    chk("midrun reset done", {31'd0, done8}, 32'd0);
    chk("midrun reset sum",  {24'd0, sum8},  32'd0);
    chk("midrun reset cout", {31'd0, cout8}, 32'd0);
    sb8.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("post reset idle", {31'd0, busy8}, 32'd0);
    go8(8'h05, 8'h03, 1'b0);
    wait_done8(8, "post reset");
    step();

    // WIDTH=2 exhaustive, issued back-to-back from DONE.
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      go2(v[4:3], v[2:1], v[0]);
      wait_done2("w2");
    end
    step();
    chk("w2 queue empty", 32'(sb2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
